// File: rtl/xs3_conv_arbiter_if.sv
// rtl/xs3_conv_arbiter_if.sv - requester, response and serial converter signals of xs3_conv_arbiter
interface xs3_conv_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_bcd;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [3:0]     resp_xs3;
  logic           resp_err;
  logic           conv_in;
  logic           conv_out;

  modport master (
    output req_valid, req_bcd, conv_out,
    input  req_ready, resp_valid, resp_id, resp_xs3, resp_err, conv_in
  );

  modport slave (
    input  req_valid, req_bcd, conv_out,
    output req_ready, resp_valid, resp_id, resp_xs3, resp_err, conv_in
  );
endinterface

// File: rtl/xs3_conv_arbiter.sv
// rtl/xs3_conv_arbiter.sv - round-robin sharing of one serial BCD-to-XS3 converter among N requesters
// Optional digit range check enabled by defining XS3_ARB_BCD_CHECK_EN.
module xs3_conv_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input logic              clk,
  input logic              rst,
  xs3_conv_arbiter_if.slave bus
);
  typedef enum logic [3:0] {
    PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, PH8, WAIT
  } phase_t;

  phase_t         phase;
  logic [IDW-1:0] last;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic [3:0]     gnt_bcd;
  logic           gnt_err;
  logic           grant_win;

  // cur_* belongs to the frame being fed in; res_* to the frame whose result is completing
  logic [3:0]     cur_bcd;
  logic [IDW-1:0] cur_id;
  logic           cur_busy;
  logic           cur_err;
  logic [IDW-1:0] res_id;
  logic           res_busy;
  logic           res_err;
  logic [2:0]     cap;

  assign grant_win = (phase == WAIT) || (phase == PH8);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_found && bus.req_valid[IDW'((int'(last) + k) % N)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(last) + k) % N);
      end
    end
    gnt_bcd = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == gnt_idx) gnt_bcd = bus.req_bcd[4*i +: 4];
    end
`ifdef XS3_ARB_BCD_CHECK_EN
    gnt_err = (gnt_bcd > 4'd9);
`else
    gnt_err = 1'b0;
`endif
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_win && gnt_found && !rst) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase          <= WAIT;
      last           <= IDW'(N - 1);
      cur_bcd        <= '0;
      cur_id         <= '0;
      cur_busy       <= 1'b0;
      cur_err        <= 1'b0;
      res_id         <= '0;
      res_busy       <= 1'b0;
      res_err        <= 1'b0;
      cap            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_xs3   <= '0;
      bus.resp_err   <= 1'b0;
      bus.conv_in    <= 1'b0;
    end else begin
      phase          <= grant_win ? PH0 : phase_t'(phase + 4'd1);
      bus.resp_valid <= 1'b0;
      bus.conv_in    <= 1'b0;
      case (phase)
        WAIT, PH8: begin
          if (phase == PH8) begin
            cap[2]   <= bus.conv_out;
            res_id   <= cur_id;
            res_busy <= cur_busy;
            res_err  <= cur_err;
          end else begin
            res_busy <= 1'b0;
          end
          cur_busy <= gnt_found;
          if (gnt_found) begin
            cur_bcd     <= gnt_bcd;
            cur_id      <= gnt_idx;
            cur_err     <= gnt_err;
            last        <= gnt_idx;
            bus.conv_in <= gnt_bcd[0] & ~gnt_err;
          end
        end
        PH0: begin
          bus.conv_in    <= cur_busy & ~cur_err & cur_bcd[1];
          bus.resp_valid <= res_busy;
          // bit 3 of the previous frame arrives only now, so it bypasses cap
          if (res_busy) begin
            bus.resp_id  <= res_id;
            bus.resp_xs3 <= res_err ? 4'd0 : {bus.conv_out, cap};
            bus.resp_err <= res_err;
          end
        end
        PH1: bus.conv_in <= cur_busy & ~cur_err & cur_bcd[2];
        PH2: bus.conv_in <= cur_busy & ~cur_err & cur_bcd[3];
        PH6: cap[0] <= bus.conv_out;
        PH7: cap[1] <= bus.conv_out;
        default: ;
      endcase
    end
  end
endmodule
